// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 constants and frame FSM state type
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam int         FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pad synchroniser, falling-edge detect, frame FSM and timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    frame_state_t           state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          to_q, to_d;
    logic                   bv_q, bv_d;
    logic                   err_q, err_d;
    logic                   fall;
    logic                   dat;

    // Index 0 is the newest sample; the chain idles high like the bus.
    assign fall = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
    assign dat  = dat_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        bv_d    = 1'b0;
        err_d   = 1'b0;
        to_d    = (state_q == IDLE) ? '0 : to_q + 1'b1;
        if (fall) begin
            to_d = '0;
            case (state_q)
                IDLE: begin
                    if (!dat) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                        shift_d = 8'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = {dat, shift_q[7:1]};
                    if (cnt_q == 3'd7) state_d = PARITY;
                    else               cnt_d   = cnt_q + 3'd1;
                end
                PARITY: begin
                    par_d   = dat;
                    state_d = STOP;
                end
                STOP: begin
                    if (dat && (^{shift_q, par_q})) bv_d  = 1'b1;
                    else                            err_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && to_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
            to_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            to_q       <= '0;
            bv_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_q       <= to_d;
            bv_q       <= bv_d;
            err_q      <= err_d;
        end
    end

    assign byte_valid = bv_q;
    assign rx_byte    = shift_q;
    assign frame_err  = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 prefix decoder, scan code strobe and per-key held state
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h174, 9'h16B, 9'h175, 9'h05A},
    parameter int                    SYNC_STAGES    = 3,
    parameter int                    TIMEOUT_CYCLES = 5000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                code_valid,
    output logic [7:0]          code,
    output logic                code_ext,
    output logic                code_brk,
    output logic                frame_err
);

    logic                byte_valid;
    logic [7:0]          rx_byte;
    logic                rx_err;
    logic                ext_q, ext_d, brk_q, brk_d;
    logic [7:0]          code_q, code_d;
    logic                cext_q, cext_d, cbrk_q, cbrk_d;
    logic                cv_q, cv_d;
    logic [NUM_KEYS-1:0] key_q, key_d;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (rx_err)
    );

    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        code_d = code_q;
        cext_d = cext_q;
        cbrk_d = cbrk_q;
        cv_d   = 1'b0;
        key_d  = key_q;
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                code_d = rx_byte;
                cext_d = ext_q;
                cbrk_d = brk_q;
                cv_d   = 1'b1;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
                // Key bits move on the same edge that raises code_valid.
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (KEY_CODES[9*i +: 9] == {ext_q, rx_byte}) key_d[i] = ~brk_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            code_q <= 8'd0;
            cext_q <= 1'b0;
            cbrk_q <= 1'b0;
            cv_q   <= 1'b0;
            key_q  <= '0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            code_q <= code_d;
            cext_q <= cext_d;
            cbrk_q <= cbrk_d;
            cv_q   <= cv_d;
            key_q  <= key_d;
        end
    end

    assign key_state  = key_q;
    assign code_valid = cv_q;
    assign code       = code_q;
    assign code_ext   = cext_q;
    assign code_brk   = cbrk_q;
    assign frame_err  = rx_err;

endmodule
